// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives latch enables/flushes and PC enable from
// load-use, redirect, fetch-miss and data-wait conditions, with perf counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_DRen,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {StRun, StDwait, StHalted} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             mem_busy, loaduse, freeze, ihit_eff, redirect_act;

  assign mem_busy = (mem_dREN | mem_dWEN) & ~dhit;
  assign loaduse  = ex_DRen & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign freeze   = ((state_q == StRun) & mem_busy) | ((state_q == StDwait) & ~dhit);
  // On the DWAIT exit cycle the memory port served data, so no fetch completed.
  assign ihit_eff = ihit & ~((state_q == StDwait) & dhit);

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    memwb_flush  = 1'b0;
    halted       = 1'b0;
    redirect_act = 1'b0;
    if (state_q == StHalted) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = 1'b1;
    end else if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      redirect_act = 1'b1;
    end else if (loaduse) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit_eff) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (wb_halt) state_d = StHalted;
        else if (mem_busy) state_d = StDwait;
      end
      StDwait: begin
        if (wb_halt) state_d = StHalted;
        else if (dhit) state_d = StRun;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StRun;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != StHalted && !pc_en && stall_q != {CNT_W{1'b1}}) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (redirect_act && flush_q != {CNT_W{1'b1}}) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the enable/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC enable.
- Resolves four conditions: load-use hazards, EX-stage control redirects (branch taken, jump, jr), instruction-fetch misses and data-memory waits.
- A small state machine tracks the data-wait and halt conditions.
- Also keeps saturating stall and flush counters for performance debug.

Parameters:
CNT_W, 16, width of the stall_cycles and flush_events counters

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_dREN  in  1  MEM-stage instruction requests a data read
mem_dWEN  in  1  MEM-stage instruction requests a data write
ex_DRen  in  1  EX-stage instruction is a load
ex_rt  in  5  EX-stage load destination register
id_rs  in  5  ID-stage source register rs
id_rt  in  5  ID-stage source register rt
id_uses_rt  in  1  ID-stage instruction reads rt as a source
ex_redirect  in  1  EX stage resolved a taken branch, jump or jr
wb_halt  in  1  halt instruction is in WB
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID latch enable
ifid_flush  out  1  IF/ID latch loads a bubble
idex_en  out  1  ID/EX latch enable
idex_flush  out  1  ID/EX latch loads a bubble
exmem_en  out  1  EX/MEM latch enable
memwb_en  out  1  MEM/WB latch enable
memwb_flush  out  1  MEM/WB latch loads a bubble
halted  out  1  CPU halted (sticky)
stall_cycles  out  CNT_W  cycles with pc_en=0 while not halted
flush_events  out  CNT_W  count of redirects acted on

Behaviour:
- States: RUN, DWAIT, HALTED. Reset: state=RUN, both counters=0.
- Control outputs are combinational from state and inputs; they are not registered.
- Defaults: all _en=1, all _flush=0, halted=0.
- Derived signals:
  - mem_busy = (mem_dREN|mem_dWEN) & !dhit
  - loaduse = ex_DRen & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))
- Output priority, highest first:
  1. HALTED: all _en=0, all _flush=0, halted=1.
  2. Memory freeze (RUN & mem_busy, or DWAIT & !dhit):
     - pc_en=ifid_en=idex_en=exmem_en=0
     - memwb_en=1, memwb_flush=1
  3. ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1; ihit and loaduse are ignored.
  4. loaduse: pc_en=0, ifid_en=0, idex_flush=1; EX/MEM and MEM/WB advance.
  5. !ihit: pc_en=0, ifid_flush=1; ID/EX onward advance.
- DWAIT exit cycle (DWAIT & dhit): data completes, and the arbiter granted memory to the data side, so ihit is treated as 0 this cycle. Rules 3–5 then apply with that forced value.
- Transitions:
  - RUN→HALTED on wb_halt (highest priority).
  - RUN→DWAIT on mem_busy.
  - DWAIT→RUN on dhit.
  - DWAIT→HALTED on wb_halt.
  - HALTED is left only by reset.
- Counters:
  - stall_cycles += 1 each cycle with state!=HALTED and pc_en=0.
  - flush_events += 1 each cycle rule 3 applies.
  - Both saturate at 2^CNT_W-1; no wrap.
  - Both freeze in HALTED.
- Simultaneous events:
  - Redirect during a memory freeze is not counted. It is acted on in the first unfrozen cycle, since EX is held and ex_redirect persists.
  - wb_halt together with mem_busy: HALTED wins.
  - Register 0 never causes loaduse.
- Reset asserted mid-operation: state→RUN, counters→0 immediately (asynchronous). Outputs then follow the defaults and the priority rules for the current inputs.

Test Plan:
- Reset, then ihit=1 with no hazards → all _en=1, _flush=0, stall_cycles=0, flush_events=0 for 10 cycles.
- ex_DRen=1, ex_rt=5, id_rs=5, ihit=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cycles=1. Repeat with ex_rt=0 → no stall.
- mem_dREN=1, dhit=0 for 3 cycles, then dhit=1, with ihit=1 throughout:
  - Freeze cycles: memwb_flush=1, front latches frozen.
  - Exit cycle: pc_en=0, ifid_flush=1 (ihit forced 0).
  - stall_cycles=4.
- ex_redirect=1 together with loaduse and ihit=0 → pc_en=1, ifid_flush=1, idex_flush=1; flush_events=1. Redirect held during a 2-cycle mem_busy → flush_events still 1, incremented only after release.
- wb_halt=1 with mem_busy=1 → next cycle halted=1, all _en=0; counters frozen until nRST pulse, after which halted=0 and counters=0.
- CNT_W=4, hold ihit=0 for 20 cycles → stall_cycles saturates at 15.
